// File: rtl/lsu_pkg.sv
// Shared size codes, encoded write strobes, FSM states and request decode helpers
// for the load/store front-end of data_memory.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // data_memory takes an encoded lane selector, not a byte-enable mask.
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_B1   = 4'b0010;
  localparam logic [3:0] STRB_B2   = 4'b0011;
  localparam logic [3:0] STRB_B3   = 4'b0100;
  localparam logic [3:0] STRB_H0   = 4'b0101;
  localparam logic [3:0] STRB_H1   = 4'b0110;
  localparam logic [3:0] STRB_W    = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_LOAD_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    strb = STRB_NONE;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0:    strb = STRB_B0;
          2'd1:    strb = STRB_B1;
          2'd2:    strb = STRB_B2;
          default: strb = STRB_B3;
        endcase
      end
      SZ_HALF: strb = lo[1] ? STRB_H1 : STRB_H0;
      SZ_WORD: strb = STRB_W;
      default: strb = STRB_NONE;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       lo_i,
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[8*lo_i +: 8];
    half_w = word_i[16*lo_i[1] +: 16];
    case (size_i)
      SZ_BYTE: data_o = {{(WIDTH-8){~uns_i & byte_w[7]}}, byte_w};
      SZ_HALF: data_o = {{(WIDTH-16){~uns_i & half_w[15]}}, half_w};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Converts byte-addressed load/store requests into single data_memory word
// transactions, one at a time, with registered memory and response outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
  output logic [$clog2(DEPTH)-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]         mem_wr_din,
  output logic [3:0]               mem_wr_strb,
  output logic                     mem_we,
  input  logic [WIDTH-1:0]         mem_rd_dout
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [1:0]       lo_q, lo_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_din_q, wr_din_d;
  logic [3:0]       wr_strb_q, wr_strb_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] load_data;

  lsu_load_align #(.WIDTH(WIDTH)) u_align (
    .word_i (mem_rd_dout),
    .lo_i   (lo_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (load_data)
  );

  assign req_ready = (state_q == S_IDLE) && rst;

  // NOTE: every *_d gets a default first so no path through the case leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_din_d    = wr_din_q;
    wr_strb_d   = STRB_NONE;
    we_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          lo_d   = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we) begin
            // Memory outputs are registered, so they are set up on the way into STORE.
            state_d   = S_STORE;
            we_d      = 1'b1;
            wr_addr_d = req_addr[ADDR_W-1:2];
            wr_strb_d = store_strb(req_size, req_addr[1:0]);
            case (req_size)
              SZ_BYTE: wr_din_d = WIDTH'(req_wdata[7:0]);
              SZ_HALF: wr_din_d = WIDTH'(req_wdata[15:0]);
              default: wr_din_d = req_wdata;
            endcase
          end else begin
            state_d   = S_LOAD;
            rd_addr_d = req_addr[ADDR_W-1:2];
          end
        end
      end
      S_STORE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      S_LOAD: state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_data;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      wr_strb_q   <= STRB_NONE;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      wr_strb_q   <= wr_strb_d;
      we_q        <= we_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_din  = wr_din_q;
  assign mem_wr_strb = wr_strb_q;
  assign mem_we      = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// responses and memory writes; independent monitors compare what the DUT presents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  mem_rd_addr;
  logic [6:0]  mem_wr_addr;
  logic [31:0] mem_wr_din;
  logic [3:0]  mem_wr_strb;
  logic        mem_we;
  logic [31:0] mem_rd_dout = '0;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_rd_addr  (mem_rd_addr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_din   (mem_wr_din),
    .mem_wr_strb  (mem_wr_strb),
    .mem_we       (mem_we),
    .mem_rd_dout  (mem_rd_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [6:0]  idx;
    logic [3:0]  strb;
    logic [31:0] din;
  } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [7:0]  ref_bytes [512];
  logic [31:0] dmem [128];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          bp_force = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // data_memory stand-in: registered read, encoded lane strobe with low-aligned data.
  always @(posedge clk) begin
    mem_rd_dout <= dmem[mem_rd_addr];
    if (mem_we) begin
      case (mem_wr_strb)
        4'd1: dmem[mem_wr_addr][7:0]   <= mem_wr_din[7:0];
        4'd2: dmem[mem_wr_addr][15:8]  <= mem_wr_din[7:0];
        4'd3: dmem[mem_wr_addr][23:16] <= mem_wr_din[7:0];
        4'd4: dmem[mem_wr_addr][31:24] <= mem_wr_din[7:0];
        4'd5: dmem[mem_wr_addr][15:0]  <= mem_wr_din[15:0];
        4'd6: dmem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
        4'd7: dmem[mem_wr_addr]        <= mem_wr_din;
        default: ;
      endcase
    end
  end

  // Memory-write monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          fail("unexpected_mem_write");
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 32'(mem_wr_addr), 32'(w.idx));
          check("wr_strb", 32'(mem_wr_strb), 32'(w.strb));
          check("wr_din", mem_wr_din, w.din);
        end
      end else begin
        check("strb_idle", 32'(mem_wr_strb), 32'd0);
      end
    end
  end

  // Response monitor; also plays the consumer and applies backpressure.
  bit          in_rsp = 0;
  int          wait_left = 0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  always @(negedge clk) begin
    if (!rst) begin
      in_rsp    = 0;
      rsp_ready = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1;
        if (rsp_q.size() == 0) begin
          fail("unexpected_rsp");
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", 32'(rsp_err), 32'(r.err));
          check("rsp_latency", 32'(cyc - r.acc + 1), 32'(r.lat));
        end
        hold_rdata = rsp_rdata;
        hold_err   = rsp_err;
        wait_left  = bp_force ? 3 : int'($urandom_range(0, 2));
      end else begin
        check("rsp_hold_rdata", rsp_rdata, hold_rdata);
        check("rsp_hold_err", 32'(rsp_err), 32'(hold_err));
      end
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (wait_left > 0) begin
        rsp_ready = 1'b0;
        wait_left--;
      end else begin
        rsp_ready = 1'b1;
      end
    end else begin
      if (in_rsp && !rsp_ready) fail("rsp_dropped_early");
      in_rsp    = 0;
      rsp_ready = 1'b0;
    end
  end

  // Issues one request; returns just after the accept edge. With track=0 the
  // transaction is expected to be aborted, so nothing is predicted.
  task automatic send(input logic we, input logic [8:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input bit track);
    int          k;
    int          n;
    bit          err;
    rsp_t        r;
    wr_t         w;
    logic [31:0] v;
    logic [31:0] mask;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail("req_ready_timeout");
      return;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    if (track) begin
      n    = 1 << size;
      err  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
      mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      r.acc = cyc + 1;
      if (err) begin
        r.rdata = '0; r.err = 1'b1; r.lat = 1;
      end else if (we) begin
        for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = 8'(wdata >> (8 * i));
        w.idx  = addr[8:2];
        w.strb = (size == 2'd0) ? 4'(addr[1:0]) + 4'd1 : (size == 2'd1) ? (addr[1] ? 4'd6 : 4'd5) : 4'd7;
        w.din  = wdata & mask;
        wr_q.push_back(w);
        r.rdata = '0; r.err = 1'b0; r.lat = 2;
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        r.rdata = v; r.err = 1'b0; r.lat = 3;
      end
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((rsp_q.size() != 0 || rsp_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0 || rsp_valid) fail("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_bytes[i] = 8'h00;
    for (int i = 0; i < 128; i++) dmem[i] = 32'h0;

    #3;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wr_strb", 32'(mem_wr_strb), 32'd0);
    check("rst_wr_din", mem_wr_din, 32'd0);
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    send(1'b1, 9'h000, 2'd2, 1'b0, 32'h1234_5678, 1);
    send(1'b1, 9'h004, 2'd0, 1'b0, 32'h0000_00AA, 1);
    send(1'b1, 9'h005, 2'd0, 1'b0, 32'hFFFF_FFBB, 1);
    send(1'b1, 9'h006, 2'd0, 1'b0, 32'h0000_00CC, 1);
    send(1'b1, 9'h007, 2'd0, 1'b0, 32'h1234_56DD, 1);
    send(1'b0, 9'h004, 2'd2, 1'b0, 32'h0, 1);
    send(1'b0, 9'h007, 2'd0, 1'b0, 32'h0, 1);
    send(1'b0, 9'h007, 2'd0, 1'b1, 32'h0, 1);
    send(1'b0, 9'h006, 2'd1, 1'b0, 32'h0, 1);
    send(1'b0, 9'h006, 2'd1, 1'b1, 32'h0, 1);
    send(1'b1, 9'h008, 2'd1, 1'b0, 32'hABCD_1234, 1);
    send(1'b1, 9'h00A, 2'd1, 1'b0, 32'h0000_5678, 1);
    send(1'b0, 9'h008, 2'd2, 1'b0, 32'h0, 1);
    send(1'b0, 9'h00A, 2'd1, 1'b0, 32'h0, 1);
    send(1'b0, 9'h009, 2'd1, 1'b0, 32'h0, 1);
    send(1'b1, 9'h009, 2'd1, 1'b0, 32'hFFFF_FFFF, 1);
    send(1'b0, 9'h00E, 2'd2, 1'b0, 32'h0, 1);
    send(1'b1, 9'h00E, 2'd2, 1'b0, 32'hFFFF_FFFF, 1);
    send(1'b0, 9'h010, 2'd3, 1'b0, 32'h0, 1);
    send(1'b1, 9'h010, 2'd3, 1'b0, 32'hFFFF_FFFF, 1);
    drain();

    bp_force = 1;
    send(1'b0, 9'h000, 2'd2, 1'b0, 32'h0, 1);
    drain();
    send(1'b1, 9'h1FC, 2'd2, 1'b0, 32'hCAFE_F00D, 1);
    drain();
    bp_force = 0;

    // Reset pulled during the STORE cycle: write must vanish with no response.
    send(1'b1, 9'h000, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
    #1;
    check("abort_we_before", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_we_after", 32'(mem_we), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    send(1'b0, 9'h000, 2'd2, 1'b0, 32'h0, 1);
    drain();

    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), sz,
           1'($urandom_range(0, 1)), $urandom, 1);
    end
    drain();
    repeat (3) @(negedge clk);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
